fwd_scoreboard: RTL

Parametrised forwarding and hazard unit for the pipelined datapath. It is the successor to the single-stage WB forwarding check.
- Tracks the destination registers of the last DEPTH in-flight instructions in an internal shift register.
- For each of NUM_SRC decode-stage source operands, it selects the youngest ready producer.
- Raises a load-use stall when the youngest matching producer's data is not yet available.
- Sits beside the decode/EX boundary and drives the operand bypass muxes.

---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_src_select.sv | 34 +++
 rtl/fwd_scoreboard.sv | 106 ++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
package fwd_pkg;

    // Widest register address an entry can hold; narrower addresses are zero-extended.
    localparam int unsigned DST_W_MAX = 8;

    localparam logic [DST_W_MAX-1:0] REG_ZERO   = '0;
    localparam int unsigned          FWD_SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 regWrite;
        logic                 isLoad;
        logic [DST_W_MAX-1:0] dst;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_src_select.sv
// Per-operand youngest-producer search: forward select or load-use hazard.
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  fwd_entry_t [DEPTH-1:0] entries,
    input  logic [DST_W_MAX-1:0]   src,
    input  logic                   used,
    output logic [SEL_W-1:0]       sel_c,
    output logic                   hazard_c
);

    // Scan oldest to youngest so the youngest match is the last one to write.
    always_comb begin
        sel_c    = SEL_W'(FWD_SEL_RF);
        hazard_c = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (used && entries[i].valid && entries[i].regWrite &&
                entries[i].dst == src && entries[i].dst != REG_ZERO) begin
                if (!entries[i].isLoad || (i + 1) > int'(LOAD_LAT)) begin
                    sel_c    = SEL_W'(i + 1);
                    hazard_c = 1'b0;
                end else begin
                    sel_c    = SEL_W'(FWD_SEL_RF);
                    hazard_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: in-flight destination tracker,
// per-operand bypass selects and a saturating stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          issue_valid,
    input  logic                          issue_regWrite,
    input  logic                          issue_isLoad,
    input  logic [REG_ADDR_W-1:0]         issue_dst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic                          flush,
    input  logic                          stall_in,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_count
);

    if (REG_ADDR_W > DST_W_MAX) begin : g_bad_addr_w
        $error("REG_ADDR_W exceeds DST_W_MAX");
    end
    if ((1 << SEL_W) < DEPTH + 1) begin : g_bad_sel_w
        $error("SEL_W too narrow to encode DEPTH");
    end
    if (LOAD_LAT >= DEPTH) begin : g_bad_load_lat
        $error("LOAD_LAT must be below DEPTH");
    end

    fwd_entry_t [DEPTH-1:0] stage_q;
    fwd_entry_t [DEPTH-1:0] stage_d;
    fwd_entry_t             issue_entry;
    logic [NUM_SRC-1:0]     hazard;
    logic [CNT_W-1:0]       cnt_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_select #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_sel (
            .entries  (stage_q),
            .src      (DST_W_MAX'(src_addr[i*REG_ADDR_W +: REG_ADDR_W])),
            .used     (src_used[i]),
            .sel_c    (fwd_sel[i*SEL_W +: SEL_W]),
            .hazard_c (hazard[i])
        );
    end

    assign stall       = issue_valid && !flush && (|hazard);
    assign stall_count = cnt_q;

    // A stalled or flushed decode slot becomes a bubble.
    always_comb begin
        issue_entry = '0;
        if (issue_valid && !stall && !flush) begin
            issue_entry.valid    = 1'b1;
            issue_entry.regWrite = issue_regWrite;
            issue_entry.isLoad   = issue_isLoad;
            issue_entry.dst      = DST_W_MAX'(issue_dst);
        end
    end

    // Shift unless frozen; a flushed stage-1 entry never advances to stage 2.
    always_comb begin
        stage_d = stage_q;
        if (!stall_in) begin
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                if (k == 1 && flush) begin
                    stage_d[k] = '0;
                end else begin
                    stage_d[k] = stage_q[k-1];
                end
            end
            stage_d[0] = issue_entry;
        end else if (flush) begin
            stage_d[0] = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else if (stall && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
